// File: rtl/eth_hdr_strip_64_if.sv
// 64-bit Avalon-ST beat bundle used on both sides of the Ethernet header stripper.
// The master side sources the beat and the slave side returns ready.
interface eth_hdr_strip_64_if #(
    parameter int ERR_W = 6
) ();
    logic [63:0]      data;
    logic             valid;
    logic             ready;
    logic             sop;
    logic             eop;
    logic [2:0]       empty;
    logic [ERR_W-1:0] error;

    modport master (output data, valid, sop, eop, empty, error, input ready);
    modport slave  (input data, valid, sop, eop, empty, error, output ready);
endinterface

// File: rtl/eth_hdr_strip_64.sv
// Strips the 14-byte Ethernet header from a 64-bit Avalon-ST frame stream, publishes it on
// sideband registers and re-emits the payload realigned so frame byte 14 lands in data[7:0].
module eth_hdr_strip_64 #(
    parameter int          ERR_W       = 6,
    parameter logic [15:0] ETYPE_MATCH = 16'h0000
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    eth_hdr_strip_64_if.slave         asi_in,
    eth_hdr_strip_64_if.master        aso_out,
    output logic [47:0]               hdr_dst_mac,
    output logic [47:0]               hdr_src_mac,
    output logic [15:0]               hdr_ethertype,
    output logic                      hdr_valid,
    output logic                      stat_runt,
    output logic                      stat_orphan,
    output logic                      stat_filtered
);

    typedef enum logic [2:0] {
        IDLE,
        HDR1,
        BODY,
        FLUSH,
        DISCARD
    } state_t;

    state_t           state;
    logic [63:0]      sop_word;
    logic [15:0]      hold;
    logic             first;
    logic [ERR_W-1:0] err_acc;
    logic [2:0]       saved_empty;

    logic             slot_free;
    logic             in_fire;
    logic [3:0]       in_bytes;
    logic [63:0]      in_word;
    logic [15:0]      cur_etype;
    logic             etype_ok;

    assign slot_free    = !aso_out.valid || aso_out.ready;
    assign asi_in.ready = (state != FLUSH) && slot_free;
    assign in_fire      = asi_in.valid && asi_in.ready;
    assign in_bytes     = asi_in.eop ? (4'd8 - {1'b0, asi_in.empty}) : 4'd8;

    // Zero the invalid top bytes of an eop beat once here so every later path emits clean data.
    always_comb begin
        in_word = asi_in.data;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) >= in_bytes) begin
                in_word[8*i +: 8] = 8'h00;
            end
        end
    end

    assign cur_etype = {in_word[39:32], in_word[47:40]};
    assign etype_ok  = (ETYPE_MATCH == 16'h0000) || (cur_etype == ETYPE_MATCH);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sop_word      <= '0;
            hold          <= '0;
            first         <= 1'b0;
            err_acc       <= '0;
            saved_empty   <= '0;
            aso_out.valid <= 1'b0;
            aso_out.data  <= '0;
            aso_out.sop   <= 1'b0;
            aso_out.eop   <= 1'b0;
            aso_out.empty <= '0;
            aso_out.error <= '0;
            hdr_dst_mac   <= '0;
            hdr_src_mac   <= '0;
            hdr_ethertype <= '0;
            hdr_valid     <= 1'b0;
            stat_runt     <= 1'b0;
            stat_orphan   <= 1'b0;
            stat_filtered <= 1'b0;
        end else begin
            hdr_valid     <= 1'b0;
            stat_runt     <= 1'b0;
            stat_orphan   <= 1'b0;
            stat_filtered <= 1'b0;

            if (slot_free) begin
                aso_out.valid <= 1'b0;
            end

            // sop is only meaningful in IDLE; elsewhere the beat is just more frame data.
            if (in_fire) begin
                err_acc <= ((state == IDLE && asi_in.sop) ? '0 : err_acc) | asi_in.error;
            end

            case (state)
                IDLE: begin
                    if (in_fire) begin
                        if (asi_in.sop) begin
                            sop_word <= in_word;
                            if (asi_in.eop) begin
                                stat_runt <= 1'b1;
                            end else begin
                                state <= HDR1;
                            end
                        end else begin
                            stat_orphan <= 1'b1;
                        end
                    end
                end

                HDR1: begin
                    if (in_fire) begin
                        hold        <= in_word[63:48];
                        saved_empty <= asi_in.empty;
                        first       <= 1'b1;
                        if (asi_in.eop && in_bytes <= 4'd6) begin
                            stat_runt <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            // Header registers change only together with the hdr_valid pulse.
                            hdr_valid     <= 1'b1;
                            hdr_dst_mac   <= {sop_word[7:0], sop_word[15:8], sop_word[23:16],
                                              sop_word[31:24], sop_word[39:32], sop_word[47:40]};
                            hdr_src_mac   <= {sop_word[55:48], sop_word[63:56], in_word[7:0],
                                              in_word[15:8], in_word[23:16], in_word[31:24]};
                            hdr_ethertype <= cur_etype;
                            if (!etype_ok) begin
                                stat_filtered <= 1'b1;
                                state         <= asi_in.eop ? IDLE : DISCARD;
                            end else if (asi_in.eop) begin
                                state <= FLUSH;
                            end else begin
                                state <= BODY;
                            end
                        end
                    end
                end

                BODY: begin
                    if (in_fire) begin
                        aso_out.valid <= 1'b1;
                        aso_out.data  <= {in_word[47:0], hold};
                        aso_out.sop   <= first;
                        first         <= 1'b0;
                        hold          <= in_word[63:48];
                        if (asi_in.eop && in_bytes <= 4'd6) begin
                            aso_out.eop   <= 1'b1;
                            aso_out.empty <= asi_in.empty - 3'd2;
                            aso_out.error <= err_acc | asi_in.error;
                            state         <= IDLE;
                        end else begin
                            aso_out.eop   <= 1'b0;
                            aso_out.empty <= '0;
                            aso_out.error <= '0;
                            if (asi_in.eop) begin
                                saved_empty <= asi_in.empty;
                                state       <= FLUSH;
                            end
                        end
                    end
                end

                // One or two leftover bytes remain in hold; emit them as the closing beat.
                FLUSH: begin
                    if (slot_free) begin
                        aso_out.valid <= 1'b1;
                        aso_out.data  <= {48'h0, hold};
                        aso_out.sop   <= first;
                        aso_out.eop   <= 1'b1;
                        aso_out.empty <= 3'd6 + saved_empty;
                        aso_out.error <= err_acc;
                        first         <= 1'b0;
                        state         <= IDLE;
                    end
                end

                DISCARD: begin
                    if (in_fire && asi_in.eop) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_hdr_strip_64.sv
// Directed bench for eth_hdr_strip_64: one unfiltered instance and one filtering on ethertype 0x0800.
module tb_eth_hdr_strip_64;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [5:0]  error;
    } beat_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic [7:0] frame [0:127];
    beat_t      q0[$];
    beat_t      q1[$];

    int hv0_cnt, runt0_cnt, orphan0_cnt, filt0_cnt;
    int hv1_cnt, runt1_cnt, filt1_cnt;

    logic [47:0] dst0, src0, dst1, src1;
    logic [15:0] etype0, etype1;
    logic        hv0, runt0, orphan0, filt0;
    logic        hv1, runt1, orphan1, filt1;

    eth_hdr_strip_64_if #(.ERR_W(6)) in0 ();
    eth_hdr_strip_64_if #(.ERR_W(6)) out0 ();
    eth_hdr_strip_64_if #(.ERR_W(6)) in1 ();
    eth_hdr_strip_64_if #(.ERR_W(6)) out1 ();

    eth_hdr_strip_64 #(.ERR_W(6), .ETYPE_MATCH(16'h0000)) dut0 (
        .clk_in(clk), .reset_n(reset_n), .asi_in(in0), .aso_out(out0),
        .hdr_dst_mac(dst0), .hdr_src_mac(src0), .hdr_ethertype(etype0), .hdr_valid(hv0),
        .stat_runt(runt0), .stat_orphan(orphan0), .stat_filtered(filt0)
    );

    eth_hdr_strip_64 #(.ERR_W(6), .ETYPE_MATCH(16'h0800)) dut1 (
        .clk_in(clk), .reset_n(reset_n), .asi_in(in1), .aso_out(out1),
        .hdr_dst_mac(dst1), .hdr_src_mac(src1), .hdr_ethertype(etype1), .hdr_valid(hv1),
        .stat_runt(runt1), .stat_orphan(orphan1), .stat_filtered(filt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture accepted output beats and count sideband pulses away from the active edge.
    always @(negedge clk) begin
        beat_t b;
        if (out0.valid && out0.ready) begin
            b = {out0.data, out0.sop, out0.eop, out0.empty, out0.error};
            q0.push_back(b);
        end
        if (out1.valid && out1.ready) begin
            b = {out1.data, out1.sop, out1.eop, out1.empty, out1.error};
            q1.push_back(b);
        end
        if (hv0) hv0_cnt++;
        if (runt0) runt0_cnt++;
        if (orphan0) orphan0_cnt++;
        if (filt0) filt0_cnt++;
        if (hv1) hv1_cnt++;
        if (runt1) runt1_cnt++;
        if (filt1) filt1_cnt++;
    end

    function automatic beat_t exp_beat(input int len, input int idx);
        beat_t b;
        int plen = len - 14;
        int nb = (plen + 7) / 8;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            if (idx * 8 + k < plen) b.data[8*k +: 8] = frame[14 + idx * 8 + k];
        end
        b.sop = (idx == 0);
        b.eop = (idx == nb - 1);
        if (b.eop) b.empty = 3'(nb * 8 - plen);
        return b;
    endfunction

    task automatic fill_frame(input int base);
        for (int i = 0; i < 128; i++) frame[i] = 8'(base + i);
    endtask

    task automatic clear_counts();
        q0.delete();
        q1.delete();
        hv0_cnt = 0; runt0_cnt = 0; orphan0_cnt = 0; filt0_cnt = 0;
        hv1_cnt = 0; runt1_cnt = 0; filt1_cnt = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int tgt, input logic [63:0] d, input logic s, input logic e,
                             input logic [2:0] em, input logic [5:0] er);
        logic acc;
        int   guard;
        if (tgt == 0) begin
            in0.valid = 1'b1; in0.data = d; in0.sop = s; in0.eop = e; in0.empty = em; in0.error = er;
        end else begin
            in1.valid = 1'b1; in1.data = d; in1.sop = s; in1.eop = e; in1.empty = em; in1.error = er;
        end
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = (tgt == 0) ? in0.ready : in1.ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            errors++;
            $display("[TB] FAIL in_handshake: beat not accepted, got ready=0, need ready=1");
        end
        if (tgt == 0) in0.valid = 1'b0; else in1.valid = 1'b0;
    endtask

    task automatic send_frame(input int tgt, input int len, input int err_beat, input logic [5:0] err_val);
        int nbeats = (len + 7) / 8;
        for (int b = 0; b < nbeats; b++) begin
            logic [63:0] w;
            int v;
            w = '0;
            for (int k = 0; k < 8; k++) begin
                if (b * 8 + k < len) w[8*k +: 8] = frame[b * 8 + k];
            end
            v = len - b * 8;
            if (v > 8) v = 8;
            send_beat(tgt, w, b == 0, b == nbeats - 1, (b == nbeats - 1) ? 3'(8 - v) : 3'd0,
                      (b == err_beat) ? err_val : 6'h00);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out0.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b need 0", out0.valid); end
        checks++;
        if (out0.data !== 64'h0) begin errors++; $display("[TB] FAIL reset_data: got %h need 0", out0.data); end
        checks++;
        if ({hv0, runt0, orphan0, filt0} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_pulses: got %b need 0000", {hv0, runt0, orphan0, filt0});
        end
        checks++;
        if ({dst0, src0, etype0} !== 112'h0) begin
            errors++; $display("[TB] FAIL reset_hdr: got %h need 0", {dst0, src0, etype0});
        end
    endtask

    task automatic test_full_frame();
        clear_counts();
        fill_frame(0);
        send_frame(0, 64, -1, 6'h00);
        wait_cycles(5);
        checks++;
        if (hv0_cnt !== 1) begin errors++; $display("[TB] FAIL full_hdr_valid: got %0d need 1", hv0_cnt); end
        checks++;
        if (dst0 !== 48'h000102030405) begin errors++; $display("[TB] FAIL full_dst: got %h need 000102030405", dst0); end
        checks++;
        if (src0 !== 48'h060708090A0B) begin errors++; $display("[TB] FAIL full_src: got %h need 060708090a0b", src0); end
        checks++;
        if (etype0 !== 16'h0C0D) begin errors++; $display("[TB] FAIL full_etype: got %h need 0c0d", etype0); end
        checks++;
        if (q0.size() !== 7) begin
            errors++; $display("[TB] FAIL full_beats: got %0d need 7", q0.size());
        end else begin
            checks++;
            if (q0[0].data !== 64'h1514131211100F0E || q0[0].sop !== 1'b1) begin
                errors++; $display("[TB] FAIL full_first: got %h sop %b need 1514131211100f0e sop 1", q0[0].data, q0[0].sop);
            end
            checks++;
            if (q0[6].eop !== 1'b1 || q0[6].empty !== 3'd6) begin
                errors++; $display("[TB] FAIL full_last: got eop %b empty %0d need eop 1 empty 6", q0[6].eop, q0[6].empty);
            end
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (q0[i] !== exp_beat(64, i)) begin
                    errors++; $display("[TB] FAIL full_beat%0d: got %h need %h", i, q0[i], exp_beat(64, i));
                end
            end
        end
    endtask

    task automatic test_short_frame();
        clear_counts();
        fill_frame(0);
        send_frame(0, 15, -1, 6'h00);
        wait_cycles(5);
        checks++;
        if (hv0_cnt !== 1) begin errors++; $display("[TB] FAIL short_hdr_valid: got %0d need 1", hv0_cnt); end
        checks++;
        if (q0.size() !== 1) begin
            errors++; $display("[TB] FAIL short_beats: got %0d need 1", q0.size());
        end else if (q0[0] !== {64'h0E, 1'b1, 1'b1, 3'd7, 6'h00}) begin
            errors++; $display("[TB] FAIL short_beat: got %h need %h", q0[0], {64'h0E, 1'b1, 1'b1, 3'd7, 6'h00});
        end
    endtask

    task automatic test_runt();
        clear_counts();
        fill_frame(0);
        send_frame(0, 14, -1, 6'h00);
        wait_cycles(3);
        checks++;
        if (runt0_cnt !== 1) begin errors++; $display("[TB] FAIL runt14_pulse: got %0d need 1", runt0_cnt); end
        send_frame(0, 6, -1, 6'h00);
        wait_cycles(3);
        checks++;
        if (runt0_cnt !== 2) begin errors++; $display("[TB] FAIL runt6_pulse: got %0d need 2", runt0_cnt); end
        checks++;
        if (hv0_cnt !== 0 || q0.size() !== 0) begin
            errors++; $display("[TB] FAIL runt_quiet: got hv %0d beats %0d need 0 0", hv0_cnt, q0.size());
        end
    endtask

    task automatic test_flush();
        clear_counts();
        fill_frame(0);
        send_frame(0, 23, -1, 6'h00);
        wait_cycles(5);
        checks++;
        if (q0.size() !== 2) begin
            errors++; $display("[TB] FAIL flush_beats: got %0d need 2", q0.size());
        end else begin
            checks++;
            if (q0[0] !== {64'h1514131211100F0E, 1'b1, 1'b0, 3'd0, 6'h00}) begin
                errors++; $display("[TB] FAIL flush_body: got %h need %h", q0[0], {64'h1514131211100F0E, 1'b1, 1'b0, 3'd0, 6'h00});
            end
            checks++;
            if (q0[1] !== {64'h16, 1'b0, 1'b1, 3'd7, 6'h00}) begin
                errors++; $display("[TB] FAIL flush_tail: got %h need %h", q0[1], {64'h16, 1'b0, 1'b1, 3'd7, 6'h00});
            end
        end
    endtask

    task automatic test_orphan();
        clear_counts();
        send_beat(0, 64'hDEADBEEF_01234567, 1'b0, 1'b0, 3'd0, 6'h00);
        wait_cycles(3);
        checks++;
        if (orphan0_cnt !== 1 || q0.size() !== 0) begin
            errors++; $display("[TB] FAIL orphan: got pulses %0d beats %0d need 1 0", orphan0_cnt, q0.size());
        end
    endtask

    task automatic test_backpressure();
        clear_counts();
        fill_frame(8'h30);
        fork
            send_frame(0, 40, -1, 6'h00);
            begin
                logic [63:0] held;
                int guard = 0;
                while (!out0.valid && guard < 100) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                out0.ready = 1'b0;
                held = out0.data;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    checks++;
                    if (out0.valid !== 1'b1 || out0.data !== held || in0.ready !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL stall_c%0d: got valid %b data %h in_ready %b need 1 %h 0",
                                 c, out0.valid, out0.data, in0.ready, held);
                    end
                end
                @(posedge clk);
                #1;
                out0.ready = 1'b1;
            end
        join
        wait_cycles(5);
        checks++;
        if (q0.size() !== 4) begin
            errors++; $display("[TB] FAIL stall_beats: got %0d need 4", q0.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q0[i] !== exp_beat(40, i)) begin
                    errors++; $display("[TB] FAIL stall_beat%0d: got %h need %h", i, q0[i], exp_beat(40, i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        fill_frame(0);
        send_frame(0, 23, -1, 6'h00);
        fill_frame(8'h80);
        send_frame(0, 23, -1, 6'h00);
        wait_cycles(5);
        checks++;
        if (q0.size() !== 4) begin
            errors++; $display("[TB] FAIL b2b_beats: got %0d need 4", q0.size());
        end else begin
            checks++;
            if (q0[2] !== {64'h9594939291908F8E, 1'b1, 1'b0, 3'd0, 6'h00}) begin
                errors++; $display("[TB] FAIL b2b_second: got %h need %h", q0[2], {64'h9594939291908F8E, 1'b1, 1'b0, 3'd0, 6'h00});
            end
            checks++;
            if (q0[3] !== {64'h96, 1'b0, 1'b1, 3'd7, 6'h00}) begin
                errors++; $display("[TB] FAIL b2b_tail: got %h need %h", q0[3], {64'h96, 1'b0, 1'b1, 3'd7, 6'h00});
            end
        end
    endtask

    task automatic test_filter();
        clear_counts();
        fill_frame(0);
        frame[12] = 8'h86;
        frame[13] = 8'hDD;
        send_frame(1, 32, -1, 6'h00);
        wait_cycles(5);
        checks++;
        if (filt1_cnt !== 1) begin errors++; $display("[TB] FAIL filter_pulse: got %0d need 1", filt1_cnt); end
        checks++;
        if (q1.size() !== 0) begin errors++; $display("[TB] FAIL filter_quiet: got %0d beats need 0", q1.size()); end
    endtask

    task automatic test_error();
        clear_counts();
        fill_frame(0);
        frame[12] = 8'h08;
        frame[13] = 8'h00;
        send_frame(1, 30, 2, 6'h01);
        wait_cycles(5);
        checks++;
        if (q1.size() !== 2) begin
            errors++; $display("[TB] FAIL err_beats: got %0d need 2", q1.size());
        end else begin
            beat_t e0, e1;
            e0 = exp_beat(30, 0);
            e1 = exp_beat(30, 1);
            e1.error = 6'h01;
            checks++;
            if (q1[0] !== e0) begin errors++; $display("[TB] FAIL err_mid: got %h need %h", q1[0], e0); end
            checks++;
            if (q1[1] !== e1) begin errors++; $display("[TB] FAIL err_eop: got %h need %h", q1[1], e1); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_counts();
        in0.valid = 1'b0; in0.data = '0; in0.sop = 1'b0; in0.eop = 1'b0; in0.empty = '0; in0.error = '0;
        in1.valid = 1'b0; in1.data = '0; in1.sop = 1'b0; in1.eop = 1'b0; in1.empty = '0; in1.error = '0;
        out0.ready = 1'b1;
        out1.ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        wait_cycles(2);
        test_full_frame();
        test_short_frame();
        test_runt();
        test_flush();
        test_orphan();
        test_backpressure();
        test_back_to_back();
        test_filter();
        test_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
